// File: rtl/ps2_codes_pkg.sv
// PS/2 Set-2 scan codes used by the hex-entry front end, plus its prefix FSM states.
package ps2_codes_pkg;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  localparam logic [7:0] ENTER_CODE = 8'h5A;
  localparam logic [7:0] BKSP_CODE  = 8'h66;
  localparam logic [7:0] ESC_CODE   = 8'h76;

  // Make codes for hex digits 0..F (top-row numerals, then letters A..F)
  localparam logic [7:0] HEX_0 = 8'h45;
  localparam logic [7:0] HEX_1 = 8'h16;
  localparam logic [7:0] HEX_2 = 8'h1E;
  localparam logic [7:0] HEX_3 = 8'h26;
  localparam logic [7:0] HEX_4 = 8'h25;
  localparam logic [7:0] HEX_5 = 8'h2E;
  localparam logic [7:0] HEX_6 = 8'h36;
  localparam logic [7:0] HEX_7 = 8'h3D;
  localparam logic [7:0] HEX_8 = 8'h3E;
  localparam logic [7:0] HEX_9 = 8'h46;
  localparam logic [7:0] HEX_A = 8'h1C;
  localparam logic [7:0] HEX_B = 8'h32;
  localparam logic [7:0] HEX_C = 8'h21;
  localparam logic [7:0] HEX_D = 8'h23;
  localparam logic [7:0] HEX_E = 8'h24;
  localparam logic [7:0] HEX_F = 8'h2B;

  typedef enum logic [1:0] {
    S_MAKE = 2'd0,
    S_BRK  = 2'd1,
    S_EXT  = 2'd2
  } state_t;

endpackage

// File: rtl/ps2_hex_entry_if.sv
// Scan-code input and entry/commit outputs of the hex-entry block.
interface ps2_hex_entry_if #(
  parameter int DIGITS = 4
);
  localparam int VW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  logic [7:0]    code_in;
  logic          code_valid;
  logic [VW-1:0] entry;
  logic [CW-1:0] count;
  logic [VW-1:0] value;
  logic          value_valid;
  logic          error;

  modport master (
    output code_in, code_valid,
    input  entry, count, value, value_valid, error
  );

  modport slave (
    input  code_in, code_valid,
    output entry, count, value, value_valid, error
  );
endinterface

// File: rtl/ps2_hex_decode.sv
// Scan code to hex nibble lookup; combinational, hit=0 for non-digit codes.
module ps2_hex_decode
  import ps2_codes_pkg::*;
(
  input  logic [7:0] code,
  output logic       hit,
  output logic [3:0] nibble
);

  always_comb begin
    hit    = 1'b1;
    nibble = 4'h0;
    case (code)
      HEX_0: nibble = 4'h0;
      HEX_1: nibble = 4'h1;
      HEX_2: nibble = 4'h2;
      HEX_3: nibble = 4'h3;
      HEX_4: nibble = 4'h4;
      HEX_5: nibble = 4'h5;
      HEX_6: nibble = 4'h6;
      HEX_7: nibble = 4'h7;
      HEX_8: nibble = 4'h8;
      HEX_9: nibble = 4'h9;
      HEX_A: nibble = 4'hA;
      HEX_B: nibble = 4'hB;
      HEX_C: nibble = 4'hC;
      HEX_D: nibble = 4'hD;
      HEX_E: nibble = 4'hE;
      HEX_F: nibble = 4'hF;
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_hex_entry.sv
// Hex-entry editor on a PS/2 scan-code stream; 1-cycle latency from code_valid to outputs.
// No backpressure: every strobed byte is consumed; value_valid/error are single-cycle pulses.
module ps2_hex_entry
  import ps2_codes_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  ps2_hex_entry_if.slave  bus
);

  localparam int VW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  state_t        state_q, state_d;
  logic [VW-1:0] entry_q, entry_d;
  logic [CW-1:0] count_q, count_d;
  logic [VW-1:0] value_q, value_d;
  logic          vv_q, vv_d;
  logic          err_q, err_d;

  logic          dig_hit;
  logic [3:0]    dig_nibble;

  ps2_hex_decode u_decode (
    .code   (bus.code_in),
    .hit    (dig_hit),
    .nibble (dig_nibble)
  );

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    count_d = count_q;
    value_d = value_q;
    vv_d    = 1'b0;
    err_d   = 1'b0;

    if (bus.code_valid) begin
      case (state_q)
        S_BRK: state_d = S_MAKE;
        // Anything after E0 is an extended key we do not use, including keypad Enter
        S_EXT: state_d = (bus.code_in == BREAK_CODE) ? S_BRK : S_MAKE;
        default: begin
          state_d = S_MAKE;
          if (bus.code_in == BREAK_CODE) begin
            state_d = S_BRK;
          end else if (bus.code_in == EXT_CODE) begin
            state_d = S_EXT;
          end else if (dig_hit) begin
            if (count_q < CW'(DIGITS)) begin
              entry_d = (entry_q << 4) | VW'(dig_nibble);
              count_d = count_q + 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (bus.code_in == BKSP_CODE) begin
            if (count_q != '0) begin
              entry_d = entry_q >> 4;
              count_d = count_q - 1'b1;
            end
          end else if (bus.code_in == ESC_CODE) begin
            entry_d = '0;
            count_d = '0;
          end else if (bus.code_in == ENTER_CODE) begin
            if (count_q != '0) begin
              value_d = entry_q;
              vv_d    = 1'b1;
              entry_d = '0;
              count_d = '0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_MAKE;
      entry_q <= '0;
      count_q <= '0;
      value_q <= '0;
      vv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      count_q <= count_d;
      value_q <= value_d;
      vv_q    <= vv_d;
      err_q   <= err_d;
    end
  end

  assign bus.entry       = entry_q;
  assign bus.count       = count_q;
  assign bus.value       = value_q;
  assign bus.value_valid = vv_q;
  assign bus.error       = err_q;

endmodule

// File: tb/tb_ps2_hex_entry.sv
// Directed plus random scan-code streams against a digit-queue model of the hex editor.
module tb_ps2_hex_entry;

  localparam int DIGITS = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ps2_hex_entry_if #(.DIGITS(DIGITS)) bus ();

  ps2_hex_entry #(.DIGITS(DIGITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Model: typed digits as a queue (oldest first) plus two prefix flags
  int unsigned digs[$];
  bit          skip_next;
  bit          after_e0;
  int unsigned m_value;
  bit          m_vv;
  bit          m_err;

  int total = 0;
  int fails = 0;

  byte unsigned hex_tab [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                 8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

  function automatic int hexval(byte unsigned c);
    for (int i = 0; i < 16; i++) if (hex_tab[i] == c) return i;
    return -1;
  endfunction

  function automatic int unsigned m_entry();
    int unsigned e = 0;
    foreach (digs[i]) e = e * 16 + digs[i];
    return e;
  endfunction

  task automatic model_reset();
    digs.delete();
    skip_next = 0;
    after_e0  = 0;
    m_value   = 0;
    m_vv      = 0;
    m_err     = 0;
  endtask

  task automatic model_byte(byte unsigned c);
    int h;
    m_vv  = 0;
    m_err = 0;
    if (skip_next) begin
      skip_next = 0;
    end else if (after_e0) begin
      after_e0 = 0;
      if (c == 8'hF0) skip_next = 1;
    end else if (c == 8'hF0) begin
      skip_next = 1;
    end else if (c == 8'hE0) begin
      after_e0 = 1;
    end else begin
      h = hexval(c);
      if (h >= 0) begin
        if (digs.size() < DIGITS) digs.push_back(h);
        else m_err = 1;
      end else if (c == 8'h66) begin
        if (digs.size() > 0) void'(digs.pop_back());
      end else if (c == 8'h76) begin
        digs.delete();
      end else if (c == 8'h5A) begin
        if (digs.size() > 0) begin
          m_value = m_entry();
          m_vv    = 1;
          digs.delete();
        end else begin
          m_err = 1;
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".entry"}, 32'(bus.entry), m_entry());
    chk({tag, ".count"}, 32'(bus.count), digs.size());
    chk({tag, ".value"}, 32'(bus.value), m_value);
    chk({tag, ".vv"},    32'(bus.value_valid), 32'(m_vv));
    chk({tag, ".err"},   32'(bus.error), 32'(m_err));
  endtask

  // Send one byte; compare all outputs just after the sampling edge
  task automatic send(byte unsigned c, string tag);
    bus.code_in    = c;
    bus.code_valid = 1'b1;
    model_byte(c);
    @(posedge clk);
    #1;
    bus.code_valid = 1'b0;
    bus.code_in    = $urandom_range(0, 255);
    chk_all(tag);
  endtask

  task automatic idle(string tag);
    m_vv  = 0;
    m_err = 0;
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic key(byte unsigned c, string tag);
    send(c, tag);
    send(8'hF0, tag);
    send(c, tag);
  endtask

  initial begin
    byte unsigned pick [8] = '{8'hF0, 8'hE0, 8'h5A, 8'h66, 8'h76, 8'h12, 8'h00, 8'h00};
    byte unsigned c;
    bus.code_in    = 8'h00;
    bus.code_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    #3;
    chk_all("reset");

    // Empty Enter, then a digit cancelled by Escape
    send(8'h5A, "empty_enter");
    chk("empty_enter_err", 32'(bus.error), 32'd1);
    idle("empty_enter_drop");
    key(8'h2E, "esc_digit");
    send(8'h76, "esc");
    chk("esc_entry", 32'(bus.entry), 32'd0);
    idle("esc_idle");

    // 1, 2, Enter with breaks
    key(8'h16, "seq12");
    key(8'h1E, "seq12");
    send(8'h5A, "seq12_enter");
    chk("seq12_value", 32'(bus.value), 32'h0012);
    chk("seq12_vv", 32'(bus.value_valid), 32'd1);
    send(8'hF0, "seq12_brk");
    chk("seq12_vv_drop", 32'(bus.value_valid), 32'd0);
    send(8'h5A, "seq12_rel");

    // Overflow on the fifth digit
    key(8'h1C, "ovf"); key(8'h32, "ovf"); key(8'h21, "ovf"); key(8'h23, "ovf");
    chk("ovf_abcd", 32'(bus.entry), 32'hABCD);
    send(8'h24, "ovf_5th");
    chk("ovf_err", 32'(bus.error), 32'd1);
    chk("ovf_keep", 32'(bus.entry), 32'hABCD);
    send(8'hF0, "ovf_brk"); send(8'h24, "ovf_rel");
    send(8'h5A, "ovf_enter");
    chk("ovf_value", 32'(bus.value), 32'hABCD);
    idle("ovf_idle");

    // Backspace down to empty and beyond
    key(8'h26, "bs"); key(8'h25, "bs");
    chk("bs_34", 32'(bus.entry), 32'h0034);
    send(8'h66, "bs1");
    chk("bs1_entry", 32'(bus.entry), 32'h0003);
    send(8'h66, "bs2");
    chk("bs2_count", 32'(bus.count), 32'd0);
    send(8'h66, "bs3");
    chk("bs3_err", 32'(bus.error), 32'd0);

    // Extended and unknown codes with entry=7
    key(8'h3D, "ext");
    send(8'hE0, "ext"); send(8'h5A, "ext_kpenter");
    send(8'hE0, "ext"); send(8'hF0, "ext"); send(8'h5A, "ext_kprel");
    send(8'h12, "ext_shift"); send(8'hF0, "ext"); send(8'h12, "ext");
    chk("ext_entry", 32'(bus.entry), 32'h0007);
    key(8'h16, "ext_after");
    chk("ext_after_entry", 32'(bus.entry), 32'h0071);
    send(8'h76, "ext_clr");

    // Async reset while a break is pending
    key(8'h46, "rst");
    send(8'hF0, "rst_brk");
    reset_n = 1'b0;
    model_reset();
    #2;
    chk_all("rst_async");
    @(posedge clk);
    #4;
    reset_n = 1'b1;
    #2;
    send(8'h16, "rst_after");
    chk("rst_after_digit", 32'(bus.entry), 32'h0001);

    // Random stream of digits, prefixes and editing keys, with idle gaps
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 0) c = hex_tab[$urandom_range(0, 15)];
      else begin
        c = pick[$urandom_range(0, 7)];
        if (c == 8'h00) c = 8'($urandom_range(0, 255));
      end
      send(c, "rand");
      if ($urandom_range(0, 3) == 0) idle("rand_idle");
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/ps2_hex_entry.md
Name: ps2_hex_entry

Overview:
- Sequential hex-entry front end for the keyboard path. Consumes a stream of PS/2 Set-2 scan-code bytes and filters break (F0) and extended (E0) sequences.
- Accumulates hex digit make codes into a DIGITS-wide entry buffer and supports backspace, escape and enter editing keys.
- On Enter, commits the buffer as a parallel value with a one-cycle strobe. Sits between the PS/2 byte receiver and the DSP control/coefficient registers.

Parameters:
- DIGITS, 4, number of hex digits held; legal range 1..8. Value width VW = 4*DIGITS (localparam).
- CW, $clog2(DIGITS+1) (localparam), width of the digit count.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- code_in  in  8  scan-code byte from the PS/2 receiver.
- code_valid  in  1  one-cycle strobe; code_in is valid this cycle. Back-to-back strobes are legal.
- entry  out  VW  live entry buffer; last typed digit in bits [3:0].
- count  out  CW  number of digits currently in entry.
- value  out  VW  last committed value; holds until the next commit.
- value_valid  out  1  one-cycle pulse when value updates.
- error  out  1  one-cycle pulse on overflow or on an empty Enter.

Behaviour:
- Reset (async assert, sync release): entry=0, count=0, value=0, value_valid=0, error=0, state=S_MAKE.
- All outputs are registered. The effect of a byte appears on the clock edge that samples code_valid=1 (1-cycle latency). value_valid and error are high for exactly one cycle.
- Nothing changes when code_valid=0. The pulse outputs drop to 0 on the next cycle.
- Prefix FSM (advances only when code_valid=1):
  - S_MAKE:
    - F0 -> S_BRK.
    - E0 -> S_EXT.
    - any other byte -> process as a make code, stay in S_MAKE.
  - S_BRK: any byte -> discarded (key release), go to S_MAKE.
  - S_EXT:
    - F0 -> S_BRK.
    - any other byte -> discarded, go to S_MAKE. Keypad Enter (E0 5A) is therefore ignored.
- Make-code processing, in priority order:
  - Hex digit (45,16,1E,26,25,2E,36,3D,3E,46,1C,32,21,23,24,2B -> 0..F):
    - If count<DIGITS: entry <= {entry[VW-5:0], nibble}, count+1.
    - If count==DIGITS: entry and count unchanged, error pulse.
  - Backspace (66):
    - If count>0: entry <= entry>>4, count-1.
    - If count==0: no-op, no error.
  - Escape (76): entry=0, count=0. No value update.
  - Enter (5A):
    - If count>0: value <= entry, value_valid pulse, entry=0, count=0 in the same edge.
    - If count==0: error pulse, value unchanged.
  - Any other code: ignored silently (shift, ctrl, etc.).
- Typematic repeat (the same make code repeated without F0) is accepted as new digits.
- Commit value is right-aligned: with DIGITS=4, typing "A5" commits 16'h00A5.
- Reset asserted mid-sequence (e.g. after F0) returns to S_MAKE and clears the partial entry. value is also cleared.

Decomposition:
- ps2_codes_pkg holds:
  - scancode localparams: BREAK_CODE=8'hF0, EXT_CODE=8'hE0, ENTER_CODE=8'h5A, BKSP_CODE=8'h66, ESC_CODE=8'h76;
  - the 16 hex make codes;
  - FSM state encodings (S_MAKE, S_BRK, S_EXT).
- Sub-module ps2_hex_decode: combinational, code[7:0] -> {hit, nibble[3:0]}. Instantiate it once. It is the table successor, now with an explicit hit flag instead of a silent default.

Test Plan:
- Reset, then 16 -> F0 16 -> 1E -> F0 1E -> 5A -> F0 5A: value=16'h0012, one value_valid pulse, count=0 afterward, no error.
- DIGITS=4, type 1C,32,21,23,24 (each followed by its break): entry=16'hABCD after 4 digits, error pulse on the 5th, entry still 16'hABCD. Enter -> value=16'hABCD.
- Type 26,25 (entry=16'h0034), then 66 -> entry=16'h0003, count=1. Another 66 -> entry=0, count=0. A third 66 -> no change, no error.
- Empty Enter right after reset -> error pulse, value_valid=0, value=0. Type 2E then 76 -> entry=0, count=0, value stays 0.
- E0 5A, then E0 F0 5A, then 12 (shift), all with entry=16'h0007: entry, count and value are unchanged, no pulses, state returns to S_MAKE.
- Type 46, then F0, then drop reset_n while in S_BRK: entry=0, count=0, value=0 immediately. After release, 16 is accepted as digit 1 (not discarded as a break byte).
